// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared definitions for the decode-stage immediate generator.
//   - fmt_e: format select / resolved format codes (FMT_AUTO only appears as a select)
//   - RISC-V major opcode constants used by the AUTO decoder
//   - is_shift(): funct3 patterns that turn OP-IMM / OP-IMM-32 into shift forms
package imm_gen_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_J     = 3'd3,
    FMT_U     = 3'd4,
    FMT_Z     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_AUTO  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount, not an immediate
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// imm_gen_comb: purely combinational format resolve and immediate build.
// Ports:
//   ins  in  32    raw instruction word
//   sel  in  3     explicit format select, or FMT_AUTO to decode from opcode
//   imm  out XLEN  generated immediate (zero when err)
//   fmt  out 3     resolved format code 0..6
//   err  out 1     AUTO select met an opcode without an immediate
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      ins,
  input  logic [2:0]       sel,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             err
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_e            res;
  logic            auto_err;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];

  always_comb begin
    res      = FMT_I;
    auto_err = 1'b0;
    if (fmt_e'(sel) != FMT_AUTO) begin
      res = fmt_e'(sel);
    end else begin
      case (opcode)
        OP_IMM, OP_IMM32:  res = is_shift(funct3) ? FMT_SHAMT : FMT_I;
        OP_LOAD, OP_JALR:  res = FMT_I;
        OP_STORE:          res = FMT_S;
        OP_BRANCH:         res = FMT_B;
        OP_JAL:            res = FMT_J;
        OP_LUI, OP_AUIPC:  res = FMT_U;
        OP_SYSTEM:         res = funct3[2] ? FMT_Z : FMT_I;
        default:           auto_err = 1'b1;
      endcase
    end
  end

  // Sign-extending forms are built at 32 bits first, then widened as signed.
  always_comb begin
    imm32 = '0;
    case (res)
      FMT_I: imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_U: imm32 = {ins[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    imm_x = '0;
    case (res)
      FMT_Z:     imm_x = XLEN'(ins[19:15]);
      FMT_SHAMT: imm_x = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      default:   imm_x = XLEN'($signed(imm32));
    endcase
  end

  assign imm = auto_err ? '0 : imm_x;
  assign fmt = res;
  assign err = auto_err;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle immediate generator stage behind a valid/ready
// handshake with a 2-entry skid buffer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 drop both entries at next edge (beats a same-edge accept)
//   in_valid/in_ready     upstream handshake; in_ready is registered (~full)
//   in_ins, in_sel, in_tag  instruction, format select, sideband tag
//   out_valid/out_ready   downstream handshake
//   out_imm, out_fmt, out_err, out_tag  oldest buffered result
//
// state | meaning
// EMPTY | no entries; out_valid=0
// ONE   | head entry valid, skid entry free
// FULL  | head and skid entries valid; in_ready=0
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_e;

  buf_e             state, state_nxt;
  logic             accept, drain;
  logic             load_head_new, load_head_skid, load_skid;

  logic [XLEN-1:0]  c_imm;
  logic [2:0]       c_fmt;
  logic             c_err;

  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  imm_gen_comb #(.XLEN(XLEN)) u_comb (
    .ins (in_ins),
    .sel (in_sel),
    .imm (c_imm),
    .fmt (c_fmt),
    .err (c_err)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt     = ONE;
            load_head_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_head_new = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_nxt      = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output ports are the head entry registers themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm  <= '0;
      out_fmt  <= '0;
      out_err  <= 1'b0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_fmt <= '0;
      skid_err <= 1'b0;
      skid_tag <= '0;
    end else begin
      if (load_head_new) begin
        out_imm <= c_imm;
        out_fmt <= c_fmt;
        out_err <= c_err;
        out_tag <= in_tag;
      end else if (load_head_skid) begin
        out_imm <= skid_imm;
        out_fmt <= skid_fmt;
        out_err <= skid_err;
        out_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= c_imm;
        skid_fmt <= c_fmt;
        skid_err <= c_err;
        skid_tag <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_ins = '0;
  logic [2:0]  in_sel = '0;
  logic [31:0] in_tag = '0;

  logic        in_ready32, in_ready64, ov32, ov64, err32, err64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_ins(in_ins), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_err(err32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_ins(in_ins), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_err(err64), .out_tag(tag64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: immediate value as a signed integer from the field weights.
  function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                     input int xlen, output int fmt, output bit err);
    int     op;
    int     f3;
    longint v;
    bit     sgn;
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    sgn = ins[31];
    err = 1'b0;
    fmt = int'(sel);
    if (sel == 3'd7) begin
      fmt = 0;
      if (op == 'h13 || op == 'h1B)      fmt = (f3 == 1 || f3 == 5) ? 6 : 0;
      else if (op == 'h03 || op == 'h67) fmt = 0;
      else if (op == 'h23)               fmt = 1;
      else if (op == 'h63)               fmt = 2;
      else if (op == 'h6F)               fmt = 3;
      else if (op == 'h37 || op == 'h17) fmt = 4;
      else if (op == 'h73)               fmt = (f3 >= 4) ? 5 : 0;
      else                               err = 1'b1;
    end
    case (fmt)
      0: v = longint'(ins[31:20]) - (sgn ? 4096 : 0);
      1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (sgn ? 4096 : 0);
      2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
             - (sgn ? 4096 : 0);
      3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
             - (sgn ? 1048576 : 0);
      4: v = longint'(ins[31:12]) * 4096 - (sgn ? 64'sd4294967296 : 64'sd0);
      5: v = longint'(ins[19:15]);
      default: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
    endcase
    if (err) v = 0;
    return v;
  endfunction

  typedef struct packed {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        err;
    logic [31:0] tag;
  } exp_t;

  function automatic exp_t model_exp(input logic [31:0] ins, input logic [2:0] sel,
                                     input logic [31:0] tag);
    exp_t   e;
    int     f;
    bit     er;
    longint v64, v32;
    v64     = ref_imm(ins, sel, 64, f, er);
    v32     = ref_imm(ins, sel, 32, f, er);
    e.imm64 = v64;
    e.imm32 = v32[31:0];
    e.fmt   = 3'(f);
    e.err   = er;
    e.tag   = tag;
    return e;
  endfunction

  // Scoreboard: expectation pushed at acceptance, popped when the DUT delivers.
  exp_t q[$];
  exp_t mon_e;

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("valid32_occupancy", ov32, q.size() != 0);
      check("valid64_occupancy", ov64, q.size() != 0);
      check("ready32_occupancy", in_ready32, q.size() < 2);
      check("ready64_occupancy", in_ready64, q.size() < 2);
      if (ov32 && out_ready && q.size() != 0) begin
        mon_e = q.pop_front();
        check("imm32", imm32, mon_e.imm32);
        check("imm64", imm64, mon_e.imm64);
        check("fmt32", fmt32, mon_e.fmt);
        check("fmt64", fmt64, mon_e.fmt);
        check("err32", err32, mon_e.err);
        check("err64", err64, mon_e.err);
        check("tag32", tag32, mon_e.tag);
        check("tag64", tag64, mon_e.tag);
      end
      if (flush) q.delete();
      else if (in_valid && in_ready32) q.push_back(model_exp(in_ins, in_sel, in_tag));
    end
  end

  // Drive one instruction and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag);
    logic acc;
    acc      = 1'b0;
    in_ins   = ins;
    in_sel   = sel;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      acc = in_ready32;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("send_accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_chk32(input logic [31:0] ins, input logic [2:0] sel,
                            input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_err);
    send(ins, sel, ins);
    check("dir32_valid", ov32, 1'b1);
    check("dir32_imm", imm32, e_imm);
    check("dir32_fmt", fmt32, e_fmt);
    check("dir32_err", err32, e_err);
  endtask

  task automatic send_chk64(input logic [31:0] ins, input logic [2:0] sel,
                            input logic [63:0] e_imm, input logic [2:0] e_fmt);
    send(ins, sel, ins);
    check("dir64_valid", ov64, 1'b1);
    check("dir64_imm", imm64, e_imm);
    check("dir64_fmt", fmt64, e_fmt);
    check("dir64_err", err64, 1'b0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0B};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    check("rst_valid32", ov32, 1'b0);
    check("rst_valid64", ov64, 1'b0);
    check("rst_ready32", in_ready32, 1'b1);
    check("rst_imm32", imm32, 32'h0);
    check("rst_imm64", imm64, 64'h0);
    check("rst_fmt32", fmt32, 3'd0);
    check("rst_err32", err32, 1'b0);
    check("rst_tag32", tag32, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed formats
    out_ready = 1'b1;
    send_chk32(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 3'd0, 1'b0);
    send_chk32(32'hFE20AE23, 3'd7, 32'hFFFFFFFC, 3'd1, 1'b0);
    send_chk32(32'hFE000CE3, 3'd7, 32'hFFFFFFF8, 3'd2, 1'b0);
    send_chk32(32'hFFDFF0EF, 3'd7, 32'hFFFFFFFC, 3'd3, 1'b0);
    send_chk32(32'h00000033, 3'd7, 32'h0, 3'd0, 1'b1);
    send_chk32(32'h00000033, 3'd0, 32'h0, 3'd0, 1'b0);
    send_chk32(32'h000FD073, 3'd7, 32'd31, 3'd5, 1'b0);
    send_chk32(32'h03F09093, 3'd7, 32'd31, 3'd6, 1'b0);
    send_chk64(32'h800000B7, 3'd7, 64'hFFFFFFFF80000000, 3'd4);
    send_chk64(32'h03F09093, 3'd7, 64'd63, 3'd6);
    @(posedge clk);
    #1;

    // backpressure: three back-to-back pushes against a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd7;
    in_ins = rand_ins(); in_tag = 32'd100;
    @(posedge clk); #1;
    in_ins = rand_ins(); in_tag = 32'd101;
    @(posedge clk); #1;
    check("bp_full_ready", in_ready32, 1'b0);
    in_ins = rand_ins(); in_tag = 32'd102;
    @(posedge clk); #1;
    check("bp_still_full", in_ready32, 1'b0);
    check("bp_head_tag", tag32, 32'd100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_tag", tag32, 32'd101);
    check("bp_ready_back", in_ready32, 1'b1);
    @(posedge clk); #1;
    check("bp_third_tag", tag32, 32'd102);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", ov32, 1'b0);

    // flush while FULL with a simultaneous push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins = rand_ins(); in_tag = 32'd200;
    @(posedge clk); #1;
    in_ins = rand_ins(); in_tag = 32'd201;
    @(posedge clk); #1;
    in_ins = rand_ins(); in_tag = 32'd202;
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_full_valid", ov32, 1'b0);
    check("flush_full_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_nothing_out", ov32, 1'b0);
    end

    // flush while ONE with an accept-able push: the push is discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins = rand_ins(); in_tag = 32'd300;
    @(posedge clk); #1;
    in_ins = rand_ins(); in_tag = 32'd301;
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_one_valid", ov32, 1'b0);
    check("flush_one_ready", in_ready32, 1'b1);

    // async reset mid-stream
    in_valid = 1'b1;
    in_ins = rand_ins(); in_tag = 32'd400;
    @(posedge clk); #1;
    in_ins = rand_ins(); in_tag = 32'd401;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", ov32, 1'b0);
    check("midrst_imm32", imm32, 32'h0);
    check("midrst_imm64", imm64, 64'h0);
    check("midrst_tag", tag32, 32'h0);
    check("midrst_ready", in_ready32, 1'b1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 32'd402);
    check("postrst_valid", ov32, 1'b1);
    check("postrst_tag", tag32, 32'd402);
    check("postrst_imm", imm32, 32'hFFFFFFFF);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_ins    = rand_ins();
      in_sel    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
      in_tag    = $urandom();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("final_drain_empty", ov32, 1'b0);
    check("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
